coherence_control: RTL and testbench
====================================

Name: coherence_control

Overview:
- Controller end of the cache/controller interface for a CPUS-core system; it drives all cache-facing inputs and consumes all cache outputs.
- Arbitrates per-core icache/dcache requests onto one RAM port.
- Implements MSI snooping: broadcasts snoop address/invalidate, and forwards modified data cache-to-cache while writing it back to RAM.

Parameters:
CPUS, 2, number of cores (each has one icache and one dcache); pointer width is clog2(CPUS), min 1
WORD_W, 32, word width (word_t)

Ports:
CLK  in  1  clock
nRST  in  1  synchronous active-low reset, sampled on rising CLK
iREN  in  CPUS  icache read request per core
iaddr  in  CPUS*WORD_W  icache addresses
iwait  out  CPUS  icache stall (0 = iload valid this cycle)
iload  out  CPUS*WORD_W  instruction data
dREN, dWEN  in  CPUS each  dcache read / write request
daddr, dstore  in  CPUS*WORD_W each  dcache address / write data
ccwrite  in  CPUS  requester: read-exclusive intent; snooper: unused
cctrans  in  CPUS  requester: coherence transaction active; snooper: 1 = holds line Modified and will supply it
dwait  out  CPUS  dcache stall
dload  out  CPUS*WORD_W  dcache read data
ccwait  out  CPUS  snoop in progress, target cache must service snoop
ccinv  out  CPUS  invalidate snooped line
ccsnoopaddr  out  CPUS*WORD_W  snoop address
ramREN, ramWEN  out  1 each  RAM strobes
ramaddr, ramstore  out  WORD_W each  RAM address / write data
ramload  in  WORD_W  RAM read data
ramstate  in  2  0=FREE 1=BUSY 2=ACCESS 3=ERROR; a word completes only on ACCESS

Behaviour:
- Reset (nRST=0 at edge): state IDLE, both round-robin pointers 0, grant 0.
  - Outputs while in reset/IDLE: iwait=dwait=all 1, ccwait=ccinv=0, ccsnoopaddr=0, iload=dload=0, ramREN=ramWEN=0, ramaddr=ramstore=0.
  - Reset mid-transaction aborts to IDLE with strobes dropped; no partial state retained.
- States: IDLE, WB, SNOOP, C2C, MEMRD, IFETCH. Each transaction moves exactly one word.
- IDLE arbitration, registered grant, fixed class priority:
  - dWEN & !cctrans -> WB.
  - dREN & cctrans -> SNOOP.
  - iREN -> IFETCH.
  - Within a class, the round-robin start is (last d-grant+1) or (last i-grant+1); pointer updates on grant.
  - One IDLE cycle minimum between unrelated transactions.
- WB: ramWEN=1, ramaddr=daddr[g], ramstore=dstore[g]. On ramstate==ACCESS: dwait[g]=0 that cycle, then -> IDLE.
- SNOOP (1 cycle), for every j!=g:
  - ccwait[j]=1, ccsnoopaddr[j]=daddr[g], ccinv[j]=ccwrite[g]; dwait[g] stays 1.
  - Next state: C2C if any snooper cctrans[j]=1 (lowest index j = supplier s), else MEMRD.
- C2C: ccwait[j!=g] held, ccsnoopaddr[j!=g] still daddr[g], ccinv[j!=g] still ccwrite[g].
  - Drives ramWEN=1, ramaddr=daddr[s], ramstore=dstore[s], dload[g]=dstore[s].
  - On ACCESS: dwait[g]=0 and dwait[s]=0 same cycle.
- MEMRD: ramREN=1, ramaddr=daddr[g], dload[g]=ramload. On ACCESS: dwait[g]=0.
- Block continuation after C2C/MEMRD completes:
  - If cctrans[g] still 1 and dREN[g]=1 next cycle (second word), go directly to SNOOP with the same grant; no re-arbitration.
  - Otherwise -> IDLE.
- IFETCH: ramREN=1, ramaddr=iaddr[g], iload[g]=ramload. On ACCESS: iwait[g]=0, then -> IDLE.
- ramstate BUSY/FREE/ERROR: hold state and all strobes; waits stay 1, no timeout.
- Request deasserted mid-transaction: finish the current word anyway and discard the result.
- Simultaneous dcache requests from all cores: served one per transaction in round-robin order. Starvation bound: CPUS-1 dcache transactions.
- Latency: RAM word = 1 arb cycle + N RAM cycles. Snooped word = 1 arb + 1 snoop + N.

Test Plan:
- Reset: hold nRST=0 with iREN=11 -> iwait=11, dwait=11, ramREN=0, ccwait=00 on every cycle; first grant after release goes to core 0.
- Icache contention: iREN=11, iaddr0=0x100, iaddr1=0x200, RAM ACCESS after 2 cycles -> core0 gets iload=ramload(0x100) first, then core1; iwait drops for exactly one cycle each.
- Clean miss: core0 dREN=1, cctrans=1, ccwrite=0, daddr=0x40; core1 cctrans=0 -> ccwait=10, ccsnoopaddr1=0x40, ccinv=00 for 1 cycle, then MEMRD, dload0=ramload, dwait0=0.
- Modified forward: core1 dREN=1, cctrans=1, ccwrite=1, daddr=0x80; core0 answers cctrans=1 with dstore=0xDEADBEEF -> ccinv0=1, RAM write 0xDEADBEEF@0x80, dload1=0xDEADBEEF, dwait=00 same cycle.
- Priority/fairness: core0 dWEN and core1 iREN asserted together -> WB granted first, IFETCH next; two back-to-back dWEN from both cores alternate grants 0,1,0.
- Abort: assert nRST=0 during C2C with ramstate=BUSY -> next cycle IDLE, ramWEN=0, ccwait=00, all waits 1.

Source files
------------

// File: rtl/coherence_control.sv
// Controller side of the cache/controller interface: arbitrates icache/dcache
// requests onto a single RAM port and runs MSI snooping with cache-to-cache forwarding.
module coherence_control #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS*WORD_W-1:0] iaddr,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS*WORD_W-1:0] iload,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS*WORD_W-1:0] daddr,
  input  logic [CPUS*WORD_W-1:0] dstore,
  input  logic [CPUS-1:0]        ccwrite,
  input  logic [CPUS-1:0]        cctrans,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS*WORD_W-1:0] dload,
  output logic [CPUS-1:0]        ccwait,
  output logic [CPUS-1:0]        ccinv,
  output logic [CPUS*WORD_W-1:0] ccsnoopaddr,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  logic [1:0]             ramstate
);

  localparam int PW = (CPUS > 1) ? $clog2(CPUS) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WB     = 3'd1,
    SNOOP  = 3'd2,
    C2C    = 3'd3,
    MEMRD  = 3'd4,
    IFETCH = 3'd5
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   grant_q;
  logic [PW-1:0]   sup_q;
  logic [PW-1:0]   rr_d_q;
  logic [PW-1:0]   rr_i_q;

  logic [WORD_W-1:0] iaddr_a  [CPUS];
  logic [WORD_W-1:0] daddr_a  [CPUS];
  logic [WORD_W-1:0] dstore_a [CPUS];
  logic [WORD_W-1:0] iload_a  [CPUS];
  logic [WORD_W-1:0] dload_a  [CPUS];
  logic [WORD_W-1:0] snoop_a  [CPUS];

  logic [PW:0]     wb_pick, sn_pick, if_pick;
  logic            sup_found;
  logic [PW-1:0]   sup_idx;
  logic            ram_access;

  for (genvar j = 0; j < CPUS; j++) begin : g_lanes
    assign iaddr_a[j]  = iaddr[j*WORD_W +: WORD_W];
    assign daddr_a[j]  = daddr[j*WORD_W +: WORD_W];
    assign dstore_a[j] = dstore[j*WORD_W +: WORD_W];
    assign iload[j*WORD_W +: WORD_W]       = iload_a[j];
    assign dload[j*WORD_W +: WORD_W]       = dload_a[j];
    assign ccsnoopaddr[j*WORD_W +: WORD_W] = snoop_a[j];
  end

  // First requester at or after start, wrapping; MSB flags that one was found.
  function automatic logic [PW:0] rr_pick(input logic [CPUS-1:0] req, input logic [PW-1:0] start);
    logic [PW:0] res;
    int          idx;
    res = '0;
    for (int k = CPUS - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % CPUS;
      if (req[idx]) res = {1'b1, PW'(idx)};
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
    return (int'(idx) == CPUS - 1) ? '0 : idx + PW'(1);
  endfunction

  assign ram_access = (ramstate == 2'd2);
  assign wb_pick    = rr_pick(dWEN & ~cctrans, rr_d_q);
  assign sn_pick    = rr_pick(dREN & cctrans, rr_d_q);
  assign if_pick    = rr_pick(iREN, rr_i_q);

  // Lowest-index snooper that holds the line Modified supplies it
  always_comb begin
    sup_found = 1'b0;
    sup_idx   = '0;
    for (int j = CPUS - 1; j >= 0; j--) begin
      if (j != int'(grant_q) && cctrans[j]) begin
        sup_found = 1'b1;
        sup_idx   = PW'(j);
      end
    end
  end

  // Transaction FSM with registered grant, supplier and round-robin pointers
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      grant_q <= '0;
      sup_q   <= '0;
      rr_d_q  <= '0;
      rr_i_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wb_pick[PW]) begin
            grant_q <= wb_pick[PW-1:0];
            rr_d_q  <= next_ptr(wb_pick[PW-1:0]);
            state_q <= WB;
          end else if (sn_pick[PW]) begin
            grant_q <= sn_pick[PW-1:0];
            rr_d_q  <= next_ptr(sn_pick[PW-1:0]);
            state_q <= SNOOP;
          end else if (if_pick[PW]) begin
            grant_q <= if_pick[PW-1:0];
            rr_i_q  <= next_ptr(if_pick[PW-1:0]);
            state_q <= IFETCH;
          end else begin
            state_q <= IDLE;
          end
        end
        WB, IFETCH: state_q <= ram_access ? IDLE : state_q;
        SNOOP: begin
          sup_q   <= sup_idx;
          state_q <= sup_found ? C2C : MEMRD;
        end
        C2C, MEMRD: begin
          // A requester still in a coherence read continues its block without re-arbitration
          if (ram_access) state_q <= (cctrans[grant_q] && dREN[grant_q]) ? SNOOP : IDLE;
          else            state_q <= state_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output decode; everything held at idle values while reset is asserted
  always_comb begin
    iwait    = '1;
    dwait    = '1;
    ccwait   = '0;
    ccinv    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    for (int j = 0; j < CPUS; j++) begin
      iload_a[j] = '0;
      dload_a[j] = '0;
      snoop_a[j] = '0;
    end
    if (nRST) begin
      if (state_q == SNOOP || state_q == C2C) begin
        for (int j = 0; j < CPUS; j++) begin
          if (j != int'(grant_q)) begin
            ccwait[j]  = 1'b1;
            ccinv[j]   = ccwrite[grant_q];
            snoop_a[j] = daddr_a[grant_q];
          end
        end
      end
      case (state_q)
        WB: begin
          ramWEN   = 1'b1;
          ramaddr  = daddr_a[grant_q];
          ramstore = dstore_a[grant_q];
          if (ram_access) dwait[grant_q] = 1'b0;
        end
        C2C: begin
          ramWEN            = 1'b1;
          ramaddr           = daddr_a[sup_q];
          ramstore          = dstore_a[sup_q];
          dload_a[grant_q]  = dstore_a[sup_q];
          if (ram_access) begin
            dwait[grant_q] = 1'b0;
            dwait[sup_q]   = 1'b0;
          end
        end
        MEMRD: begin
          ramREN           = 1'b1;
          ramaddr          = daddr_a[grant_q];
          dload_a[grant_q] = ramload;
          if (ram_access) dwait[grant_q] = 1'b0;
        end
        IFETCH: begin
          ramREN           = 1'b1;
          ramaddr          = iaddr_a[grant_q];
          iload_a[grant_q] = ramload;
          if (ram_access) iwait[grant_q] = 1'b0;
        end
        default: ramREN = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_coherence_control.sv
// Directed bench for coherence_control (2 cores, 32-bit words).
module tb_coherence_control;

  localparam int CPUS   = 2;
  localparam int WORD_W = 32;

  logic                   CLK, nRST;
  logic [CPUS-1:0]        iREN, iwait, dREN, dWEN, ccwrite, cctrans, dwait, ccwait, ccinv;
  logic [CPUS*WORD_W-1:0] iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
  logic                   ramREN, ramWEN;
  logic [WORD_W-1:0]      ramaddr, ramstore, ramload;
  logic [1:0]             ramstate;

  int n_cmp = 0;
  int n_err = 0;

  coherence_control #(.CPUS(CPUS), .WORD_W(WORD_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ccwrite(ccwrite), .cctrans(cctrans), .dwait(dwait), .dload(dload),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  localparam logic [1:0] BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

  initial begin
    nRST = 1'b0; iREN = 2'b11; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
    iaddr = {32'h0000_0200, 32'h0000_0100}; daddr = '0; dstore = '0;
    ramload = 32'h0; ramstate = BUSY;

    // Reset held with both icaches requesting
    @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rst_iwait", 32'(iwait), 32'h3);
      chk("rst_dwait", 32'(dwait), 32'h3);
      chk("rst_ramREN", 32'(ramREN), 32'h0);
      chk("rst_ccwait", 32'(ccwait), 32'h0);
      @(negedge CLK);
    end
    nRST = 1'b1;

    // Icache contention: core0 first
    @(negedge CLK); #1;
    chk("if0_ramREN", 32'(ramREN), 32'h1);
    chk("if0_addr", ramaddr, 32'h100);
    chk("if0_iwait_busy", 32'(iwait), 32'h3);
    @(negedge CLK); ramstate = ACC; ramload = 32'h1111_0100; #1;
    chk("if0_iwait", 32'(iwait), 32'h2);
    chk("if0_iload", iload[31:0], 32'h1111_0100);
    @(negedge CLK); ramstate = BUSY; #1;
    chk("if0_iwait_once", 32'(iwait), 32'h3);
    chk("if_idle_ramREN", 32'(ramREN), 32'h0);
    @(negedge CLK); #1;
    chk("if1_addr", ramaddr, 32'h200);
    @(negedge CLK); ramstate = ACC; ramload = 32'h2222_0200; #1;
    chk("if1_iwait", 32'(iwait), 32'h1);
    chk("if1_iload", iload[63:32], 32'h2222_0200);
    iREN = 2'b00;

    // Clean miss from core0, core1 not modified
    @(negedge CLK); ramstate = BUSY;
    dREN = 2'b01; cctrans = 2'b01; ccwrite = 2'b00; daddr = {32'h0, 32'h40}; #1;
    chk("if1_iwait_once", 32'(iwait), 32'h3);
    @(negedge CLK); #1;
    chk("cm_ccwait", 32'(ccwait), 32'h2);
    chk("cm_snpaddr1", ccsnoopaddr[63:32], 32'h40);
    chk("cm_ccinv", 32'(ccinv), 32'h0);
    chk("cm_dwait_snoop", 32'(dwait), 32'h3);
    @(negedge CLK); ramstate = ERR; #1;
    chk("cm_ramREN", 32'(ramREN), 32'h1);
    chk("cm_ramaddr", ramaddr, 32'h40);
    chk("cm_dwait_err", 32'(dwait), 32'h3);
    @(negedge CLK); ramstate = ACC; ramload = 32'hCAFE_0040; #1;
    chk("cm_dload0", dload[31:0], 32'hCAFE_0040);
    chk("cm_dwait", 32'(dwait), 32'h2);
    chk("cm_ccwait_rd", 32'(ccwait), 32'h0);
    dREN = 2'b00; cctrans = 2'b00;

    // Modified forward: core1 read-exclusive, core0 supplies
    @(negedge CLK); ramstate = BUSY;
    dREN = 2'b10; cctrans = 2'b11; ccwrite = 2'b10;
    daddr = {32'h80, 32'h80}; dstore = {32'h0, 32'hDEAD_BEEF}; #1;
    chk("mf_idle_ramREN", 32'(ramREN), 32'h0);
    @(negedge CLK); #1;
    chk("mf_ccwait", 32'(ccwait), 32'h1);
    chk("mf_ccinv", 32'(ccinv), 32'h1);
    chk("mf_snpaddr0", ccsnoopaddr[31:0], 32'h80);
    @(negedge CLK); #1;
    chk("mf_ramWEN", 32'(ramWEN), 32'h1);
    chk("mf_ramstore", ramstore, 32'hDEAD_BEEF);
    chk("mf_dload1", dload[63:32], 32'hDEAD_BEEF);
    chk("mf_dwait_busy", 32'(dwait), 32'h3);
    ramstate = ACC; #1;
    chk("mf_dwait", 32'(dwait), 32'h0);
    chk("mf_ramaddr", ramaddr, 32'h80);
    dREN = 2'b00; cctrans = 2'b00; ccwrite = 2'b00;

    // Priority: core0 write-back beats core1 ifetch
    @(negedge CLK); ramstate = BUSY;
    dWEN = 2'b01; daddr = {32'h0, 32'h300}; dstore = {32'h0, 32'h0BAD_0300};
    iREN = 2'b10; iaddr = {32'h500, 32'h0};
    @(negedge CLK); #1;
    chk("pr_wb_ramWEN", 32'(ramWEN), 32'h1);
    chk("pr_wb_addr", ramaddr, 32'h300);
    chk("pr_wb_store", ramstore, 32'h0BAD_0300);
    ramstate = ACC; #1;
    chk("pr_wb_dwait", 32'(dwait), 32'h2);
    chk("pr_wb_iwait", 32'(iwait), 32'h3);
    dWEN = 2'b00;
    @(negedge CLK); ramstate = BUSY; #1;
    chk("pr_idle_ramWEN", 32'(ramWEN), 32'h0);
    @(negedge CLK); #1;
    chk("pr_if_ramREN", 32'(ramREN), 32'h1);
    chk("pr_if_addr", ramaddr, 32'h500);
    ramstate = ACC; ramload = 32'h5555_0500; #1;
    chk("pr_if_iwait", 32'(iwait), 32'h1);
    chk("pr_if_iload", iload[63:32], 32'h5555_0500);
    iREN = 2'b00;

    // Abort: reset during C2C while RAM busy
    @(negedge CLK); ramstate = BUSY;
    dREN = 2'b01; cctrans = 2'b11; ccwrite = 2'b00;
    daddr = {32'h90, 32'h90}; dstore = {32'h1234_5678, 32'h0};
    @(negedge CLK); #1;
    chk("ab_ccwait", 32'(ccwait), 32'h2);
    @(negedge CLK); #1;
    chk("ab_c2c_ramWEN", 32'(ramWEN), 32'h1);
    chk("ab_c2c_dload0", dload[31:0], 32'h1234_5678);
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1; dREN = 2'b00; cctrans = 2'b00; #1;
    chk("ab_ramWEN", 32'(ramWEN), 32'h0);
    chk("ab_ccwait_idle", 32'(ccwait), 32'h0);
    chk("ab_iwait", 32'(iwait), 32'h3);
    chk("ab_dwait", 32'(dwait), 32'h3);

    // Fairness: both cores write back continuously, grants alternate from core0
    dWEN = 2'b11; daddr = {32'h700, 32'h600}; ramstate = ACC;
    @(negedge CLK); #1;
    chk("fa_g0_addr", ramaddr, 32'h600);
    chk("fa_g0_dwait", 32'(dwait), 32'h2);
    @(negedge CLK); #1;
    chk("fa_idle_ramWEN", 32'(ramWEN), 32'h0);
    @(negedge CLK); #1;
    chk("fa_g1_addr", ramaddr, 32'h700);
    chk("fa_g1_dwait", 32'(dwait), 32'h1);
    @(negedge CLK);
    @(negedge CLK); #1;
    chk("fa_g0b_addr", ramaddr, 32'h600);
    dWEN = 2'b00;
    @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
